// File: rtl/rotation_controller_if.sv
// rotation_controller_if: frame-rate control and angle output bundle.
// master drives frame_start/run/speed_level/reverse_req; slave returns the
// registered angle, direction, applied speed and reversing flag.
interface rotation_controller_if #(
    parameter int ANGLE_W = 10,
    parameter int SPEED_W = 4
);
    logic               frame_start;
    logic               run;
    logic [SPEED_W-1:0] speed_level;
    logic               reverse_req;
    logic [ANGLE_W-1:0] rotation_offset;
    logic               direction;
    logic [SPEED_W-1:0] cur_speed;
    logic               reversing;

    modport master (
        output frame_start, run, speed_level, reverse_req,
        input  rotation_offset, direction, cur_speed, reversing
    );

    modport slave (
        input  frame_start, run, speed_level, reverse_req,
        output rotation_offset, direction, cur_speed, reversing
    );
endinterface

// File: rtl/rotation_controller.sv
// rotation_controller: per-frame global rotation angle with speed ramping,
// braking and LFSR-timed direction reversals.
// Ports: Clk, Reset_n (async, active low), ctl (slave side of the
// control/angle bundle). Outputs update one clock after a frame_start edge.
module rotation_controller #(
    parameter int          ANGLE_W        = 10,
    parameter int          SPEED_W        = 4,
    parameter int          MIN_HOLD       = 90,
    parameter int          HOLD_RAND_MASK = 63,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input logic                  Clk,
    input logic                  Reset_n,
    rotation_controller_if.slave ctl
);
    localparam int HOLD_W = $clog2(MIN_HOLD + HOLD_RAND_MASK + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        SPIN,
        BRAKE,
        FLIP
    } state_e;

    state_e             state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               dir_q, dir_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               rev_q, rev_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               pend_q, pend_d;

    logic               req_ok;
    logic               pend_now;
    logic               lfsr_fb;
    logic [SPEED_W:0]   speed_inc;
    logic [HOLD_W-1:0]  hold_dec;
    logic [HOLD_W-1:0]  hold_load;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            angle_q <= '0;
            dir_q   <= 1'b0;
            speed_q <= '0;
            rev_q   <= 1'b0;
            hold_q  <= HOLD_W'(MIN_HOLD);
            lfsr_q  <= LFSR_SEED;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            rev_q   <= rev_d;
            hold_q  <= hold_d;
            lfsr_q  <= lfsr_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        dir_d   = dir_q;
        speed_d = speed_q;
        rev_d   = rev_q;
        hold_d  = hold_q;
        lfsr_d  = lfsr_q;

        // Requests are dropped while a reversal is already under way.
        req_ok   = ctl.reverse_req && (state_q != BRAKE) && (state_q != FLIP);
        pend_now = pend_q | req_ok;
        pend_d   = ctl.run ? pend_now : 1'b0;

        lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        speed_inc = {1'b0, speed_q} + (SPEED_W+1)'(1);
        hold_dec  = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
        hold_load = HOLD_W'(MIN_HOLD)
                  + HOLD_W'(lfsr_q & 16'(HOLD_RAND_MASK));

        if (ctl.frame_start) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
            if (!ctl.run) begin
                state_d = IDLE;
                speed_d = '0;
                rev_d   = 1'b0;
            end else begin
                rev_d = 1'b0;
                unique case (state_q)
                    // IDLE with run high ramps in the same frame, so the
                    // first frame after start already moves by 1.
                    IDLE, ACCEL: begin
                        if (speed_inc >= {1'b0, ctl.speed_level}) begin
                            speed_d = ctl.speed_level;
                            state_d = SPIN;
                            hold_d  = hold_load;
                        end else begin
                            speed_d = speed_inc[SPEED_W-1:0];
                            state_d = ACCEL;
                        end
                    end
                    SPIN: begin
                        if (ctl.speed_level > speed_q) begin
                            speed_d = speed_q + SPEED_W'(1);
                        end else if (ctl.speed_level < speed_q) begin
                            speed_d = speed_q - SPEED_W'(1);
                        end
                        hold_d = hold_dec;
                        if ((hold_dec == '0) || pend_now) begin
                            state_d = BRAKE;
                            pend_d  = 1'b0;
                        end
                    end
                    BRAKE: begin
                        rev_d   = 1'b1;
                        speed_d = (speed_q == '0) ? '0 : speed_q - SPEED_W'(1);
                        if (speed_d == '0) begin
                            state_d = FLIP;
                        end
                    end
                    FLIP: begin
                        rev_d   = 1'b1;
                        speed_d = '0;
                        dir_d   = ~dir_q;
                        state_d = ACCEL;
                    end
                    default: state_d = IDLE;
                endcase
                // Speed is zero in FLIP, so the old direction is harmless.
                if (dir_q) begin
                    angle_d = angle_q - ANGLE_W'(speed_d);
                end else begin
                    angle_d = angle_q + ANGLE_W'(speed_d);
                end
            end
        end
    end

    assign ctl.rotation_offset = angle_q;
    assign ctl.direction       = dir_q;
    assign ctl.cur_speed       = speed_q;
    assign ctl.reversing       = rev_q;
endmodule
